ace_home_node: RTL

Two-port AXI-ACE home node that sits directly downstream of the per-cache `ace_controller` instances. It accepts read (AR) and write (AW/W) requests from two cache controllers and arbitrates between them round-robin. It serves data from a local word-addressed backing store and returns R/B responses. It keeps a per-word presence directory so it can drive each controller's `Shared_line` input in the same cycle the request is accepted.

---
 rtl/ace_pkg.sv | 20 ++
 rtl/ace_rr_arbiter.sv | 28 ++
 rtl/ace_home_node.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ace_pkg.sv
// Shared types and constants for the ACE home node and its arbiter.
package ace_pkg;

  localparam int unsigned ACE_NUM_M    = 2;
  localparam int unsigned ACE_WORD_LSB = 2;

  typedef enum logic [1:0] {
    HN_IDLE    = 2'd0,
    HN_RD_RESP = 2'd1,
    HN_WR_RESP = 2'd2
  } hn_state_t;

  // Request payload of the granted master.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
  } axi_ace_if_t;

endpackage

// File: rtl/ace_rr_arbiter.sv
// Two-requester round-robin arbiter; the pointer names the master with priority.
module ace_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       ptr,
  output logic [1:0] grant_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    grant_c = '0;
    if (req[ptr]) begin
      grant_c[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      grant_c[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/ace_home_node.sv
// Two-port ACE home node: round-robin AR/AW arbitration, word store, presence directory.
// Optional ACE_HN_STATS_EN adds saturating accept counters.
module ace_home_node
  import ace_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned NUM_M      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef ACE_HN_STATS_EN
  output logic [15:0]             stat_rd,
  output logic [15:0]             stat_wr,
  output logic [15:0]             stat_shared,
`endif
  input  logic [NUM_M-1:0][31:0]  araddr,
  input  logic [NUM_M-1:0]        arvalid,
  output logic [NUM_M-1:0]        arready,
  output logic [NUM_M-1:0][31:0]  rdata,
  output logic [NUM_M-1:0]        rvalid,
  input  logic [NUM_M-1:0]        rready,
  input  logic [NUM_M-1:0][31:0]  awaddr,
  input  logic [NUM_M-1:0]        awvalid,
  output logic [NUM_M-1:0]        awready,
  input  logic [NUM_M-1:0][31:0]  wdata,
  input  logic [NUM_M-1:0]        wvalid,
  output logic [NUM_M-1:0]        wready,
  output logic [NUM_M-1:0]        bvalid,
  input  logic [NUM_M-1:0]        bready,
  output logic [NUM_M-1:0]        shared
);

  localparam int unsigned WORD_W = ADDR_WIDTH - ACE_WORD_LSB;
  localparam int unsigned DEPTH  = 1 << WORD_W;

  if (NUM_M != ACE_NUM_M) begin : g_num_m_check
    $error("ace_home_node supports exactly two masters");
  end

  hn_state_t                     state, state_nxt;
  logic                          lat_m;
  logic [WORD_W-1:0]             lat_word;
  logic [31:0]                   mem      [DEPTH];
  logic [NUM_M-1:0]              presence [DEPTH];

  logic                          in_idle_c, ptr, advance_c, gm_c;
  logic [NUM_M-1:0]              elig_c, req_c, grant_c;
  logic [NUM_M-1:0][WORD_W-1:0]  word_c;
  axi_ace_if_t                   sel_c;
  logic [WORD_W-1:0]             sel_word_c;
  logic                          accept_c, rd_acc_c, wr_acc_c, rd_done_c, wr_done_c;
  logic                          unused_addr_c;

  assign in_idle_c = rst_n & (state == HN_IDLE);

  // Per-master word lookup and directory snoop, sampled before any accept-edge update.
  for (genvar g = 0; g < NUM_M; g++) begin : g_master
    assign elig_c[g]  = arvalid[g] | (awvalid[g] & wvalid[g]);
    assign word_c[g]  = arvalid[g] ? araddr[g][ADDR_WIDTH-1:ACE_WORD_LSB]
                                   : awaddr[g][ADDR_WIDTH-1:ACE_WORD_LSB];
    assign shared[g]  = rst_n & (arvalid[g] | awvalid[g]) & presence[word_c[g]][NUM_M-1-g];
    assign arready[g] = grant_c[g] & arvalid[g];
    assign awready[g] = grant_c[g] & ~arvalid[g];
    assign wready[g]  = grant_c[g] & ~arvalid[g];
  end

  assign req_c = in_idle_c ? elig_c : '0;

  ace_rr_arbiter u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_c),
    .advance (advance_c),
    .ptr     (ptr),
    .grant_c (grant_c)
  );

  assign gm_c = grant_c[1];

  always_comb begin
    sel_c.addr  = arvalid[gm_c] ? araddr[gm_c] : awaddr[gm_c];
    sel_c.data  = wdata[gm_c];
    sel_c.write = ~arvalid[gm_c];
  end

  assign sel_word_c    = sel_c.addr[ADDR_WIDTH-1:ACE_WORD_LSB];
  assign unused_addr_c = ^{sel_c.addr[31:ADDR_WIDTH], sel_c.addr[ACE_WORD_LSB-1:0], ptr};
  assign accept_c      = |grant_c;
  assign rd_acc_c      = accept_c & ~sel_c.write;
  assign wr_acc_c      = accept_c & sel_c.write;
  assign rd_done_c     = (state == HN_RD_RESP) & rready[lat_m];
  assign wr_done_c     = (state == HN_WR_RESP) & bready[lat_m];
  assign advance_c     = rd_done_c | wr_done_c;

  always_comb begin
    state_nxt = state;
    case (state)
      HN_IDLE: begin
        if (rd_acc_c)      state_nxt = HN_RD_RESP;
        else if (wr_acc_c) state_nxt = HN_WR_RESP;
      end
      HN_RD_RESP: if (rd_done_c) state_nxt = HN_IDLE;
      HN_WR_RESP: if (wr_done_c) state_nxt = HN_IDLE;
      default:    state_nxt = HN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HN_IDLE;
      lat_m    <= 1'b0;
      lat_word <= '0;
      rvalid   <= '0;
      bvalid   <= '0;
      rdata    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        presence[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (accept_c) begin
        lat_m    <= gm_c;
        lat_word <= sel_word_c;
      end
      if (rd_acc_c) begin
        rvalid      <= grant_c;
        rdata[gm_c] <= mem[sel_word_c];
      end
      // A write makes the writer the sole holder of the word.
      if (wr_acc_c) begin
        bvalid               <= grant_c;
        presence[sel_word_c] <= grant_c;
      end
      if (rd_done_c) begin
        rvalid                    <= '0;
        presence[lat_word][lat_m] <= 1'b1;
      end
      if (wr_done_c) begin
        bvalid <= '0;
      end
    end
  end

  // Backing store is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[sel_word_c] <= sel_c.data;
    end
  end

`ifdef ACE_HN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd     <= '0;
      stat_wr     <= '0;
      stat_shared <= '0;
    end else begin
      if (rd_acc_c && stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
      if (wr_acc_c && stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
      if (|(shared & grant_c) && stat_shared != 16'hFFFF) stat_shared <= stat_shared + 16'd1;
    end
  end
`endif

endmodule
